// File: rtl/scaler_pkg.sv
// Shared types and constants for the scaler configuration controller.
package scaler_pkg;

  localparam int unsigned STEP_FRAC_W = 12;
  localparam int unsigned DIV_W       = 28;

  typedef logic [15:0] step_t;
  typedef logic [15:0] lsize_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StApply
  } state_e;

endpackage

// File: rtl/scaler_div.sv
// Serial restoring divider: one quotient bit per clock, DIV_W clocks per division.
module scaler_div
  import scaler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [15:0]      divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  logic [DIV_W-1:0] quot_q, quot_d;
  logic [15:0]      rem_q, rem_d;
  logic [15:0]      dvs_q, dvs_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic [16:0]      rem_shift;
  logic             rem_ge;

  always_comb begin
    // Remainder stays below the divisor, so 16 bits hold it between steps.
    rem_shift = {rem_q, quot_q[DIV_W-1]};
    rem_ge    = rem_shift >= {1'b0, dvs_q};

    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;

    if (start) begin
      quot_d = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = 5'(DIV_W);
      run_d  = 1'b1;
    end else if (run_q) begin
      rem_d  = rem_ge ? 16'(rem_shift - {1'b0, dvs_q}) : rem_shift[15:0];
      quot_d = {quot_q[DIV_W-2:0], rem_ge};
      cnt_d  = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quot_q;

endmodule

// File: rtl/scaler_cfg_ctrl.sv
// Frame-synchronous step / line-size configuration for the scaler_h -> scaler_v pipeline.
module scaler_cfg_ctrl
  import scaler_pkg::*;
#(
  parameter int unsigned STEP_ONE      = 4096,
  parameter int unsigned STEP_MIN      = 1024,
  parameter int unsigned STEP_MAX      = 65535,
  parameter int unsigned STEP_DEFAULT  = STEP_ONE,
  parameter int unsigned LINE_SIZE_MAX = 4096
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cfg_valid_i,
  output logic   cfg_ready_o,
  input  step_t  cfg_step_i,
  input  lsize_t cfg_line_size_i,
  input  logic   vs_i,
  output step_t  step_cord_o,
  output lsize_t scale_line_size_o,
  output logic   upd_o,
  output logic   busy_o,
  output logic   err_o,
  output logic   sat_o,
  output logic   miss_o
);

  state_e state_q, state_d;

  logic   vs_q, vs_qq, frame_edge;
  logic   pend_q, pend_d;
  step_t  pend_step_q, pend_step_d;
  lsize_t pend_line_q, pend_line_d;
  step_t  work_step_q, work_step_d;
  step_t  step_q, step_d;
  lsize_t size_q, size_d;
  logic   upd_q, upd_d;
  logic   err_q, err_d;
  logic   sat_q, sat_d;
  logic   miss_q, miss_d;

  logic             cfg_fire, cfg_legal;
  logic             div_start, div_done;
  logic [DIV_W-1:0] div_quot;
  lsize_t           line_m1;
  logic [DIV_W:0]   n_full;

  assign frame_edge = vs_q & ~vs_qq;
  assign cfg_fire   = cfg_valid_i & ~pend_q;
  assign cfg_legal  = ({1'b0, cfg_step_i} >= 17'(STEP_MIN)) &&
                      ({1'b0, cfg_step_i} <= 17'(STEP_MAX)) &&
                      (cfg_line_size_i != '0);
  assign line_m1    = pend_line_q - 16'd1;
  assign n_full     = {1'b0, div_quot} + 29'd1;

  scaler_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend ({line_m1, {STEP_FRAC_W{1'b0}}}),
    .divisor  (pend_step_q),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (frame_edge && pend_q) state_d = StCalc;
      StCalc:  if (div_done) state_d = StApply;
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    div_start = (state_q == StIdle) && frame_edge && pend_q;
    busy_o    = (state_q == StCalc);
  end

  always_comb begin
    pend_d      = pend_q;
    pend_step_d = pend_step_q;
    pend_line_d = pend_line_q;
    work_step_d = work_step_q;
    step_d      = step_q;
    size_d      = size_q;
    upd_d       = 1'b0;
    err_d       = err_q;
    sat_d       = sat_q;
    miss_d      = miss_q;

    if (cfg_fire) begin
      if (cfg_legal) begin
        pend_d      = 1'b1;
        pend_step_d = cfg_step_i;
        pend_line_d = cfg_line_size_i;
        err_d       = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // The slot is freed as the divider captures it; a request on this clk saw ready low.
    if (div_start) begin
      pend_d      = 1'b0;
      work_step_d = pend_step_q;
    end

    if ((state_q == StCalc) && frame_edge) begin
      miss_d = 1'b1;
    end

    if (state_q == StApply) begin
      step_d = work_step_q;
      upd_d  = 1'b1;
      if (n_full > 29'(LINE_SIZE_MAX)) begin
        size_d = 16'(LINE_SIZE_MAX);
        sat_d  = 1'b1;
      end else begin
        size_d = n_full[15:0];
        sat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      vs_qq       <= 1'b0;
      pend_q      <= 1'b0;
      pend_step_q <= '0;
      pend_line_q <= '0;
      work_step_q <= '0;
      step_q      <= 16'(STEP_DEFAULT);
      size_q      <= '0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
      sat_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      vs_q        <= vs_i;
      vs_qq       <= vs_q;
      pend_q      <= pend_d;
      pend_step_q <= pend_step_d;
      pend_line_q <= pend_line_d;
      work_step_q <= work_step_d;
      step_q      <= step_d;
      size_q      <= size_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
      sat_q       <= sat_d;
      miss_q      <= miss_d;
    end
  end

  assign cfg_ready_o       = ~pend_q;
  assign step_cord_o       = step_q;
  assign scale_line_size_o = size_q;
  assign upd_o             = upd_q;
  assign err_o             = err_q;
  assign sat_o             = sat_q;
  assign miss_o            = miss_q;

endmodule
